// File: rtl/gigatron_pkg.sv
// gigatron_pkg: shared ROM widths and burst FSM encoding for the ROM arbiter
package gigatron_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_t;
endpackage

// File: rtl/gigatron_fifo2.sv
// gigatron_fifo2: two-entry first-word-fall-through buffer for debug read data
module gigatron_fifo2
   import gigatron_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);
   logic [DATA_W-1:0] mem_q [2];
   logic              rd_q, wr_q;
   logic [1:0]        cnt_q;
   logic              do_push, do_pop;
   assign do_pop  = i_pop && !o_empty;
   // a push into a full buffer is legal only when the head leaves this cycle
   assign do_push = i_push && (!o_full || do_pop);
   assign o_data  = mem_q[rd_q];
   assign o_full  = cnt_q == 2'd2;
   assign o_empty = cnt_q == 2'd0;
   always_ff @(posedge i_clock) begin
      if (do_push) mem_q[wr_q] <= i_data;
   end
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         rd_q  <= rd_q ^ do_pop;
         wr_q  <= wr_q ^ do_push;
         cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/gigatron_rom_arbiter.sv
// gigatron_rom_arbiter: shares one ROM port between CPU fetches and a debug burst streamer
module gigatron_rom_arbiter
   import gigatron_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   input  logic              i_cpu_en,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   output logic [DATA_W-1:0] o_cpu_data,
   output logic              o_cpu_stall,
   input  logic              i_dbg_start,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [ADDR_W-1:0] i_dbg_len,
   output logic              o_dbg_busy,
   output logic [DATA_W-1:0] o_dbg_data,
   output logic              o_dbg_valid,
   input  logic              i_dbg_ready,
   output logic              o_dbg_done
);
   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d, rom_addr_q, rom_addr_d;
   logic [31:0]       starve_q, starve_d;
   logic              inflight_q, empty_done_q, empty_done_d;
   logic              fifo_full, fifo_empty, pop, want, forced, issue;
   logic [1:0]        occ, load;

   gigatron_fifo2 u_fifo (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_push   (inflight_q),
      .i_pop    (pop),
      .i_data   (i_rom_data),
      .o_data   (o_dbg_data),
      .o_full   (fifo_full),
      .o_empty  (fifo_empty)
   );

   assign o_dbg_valid = !fifo_empty;
   assign pop         = o_dbg_valid && i_dbg_ready;
   // occupancy after this cycle's pop keeps one beat per cycle with a 2-deep buffer
   assign occ         = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
   assign load        = occ - {1'b0, pop} + {1'b0, inflight_q};
   assign want        = (state_q == RUN) && (rem_q != '0) && (load < 2'd2);
   assign forced      = (STARVE_LIMIT != 0) && want && (starve_q == 32'(STARVE_LIMIT));
   assign issue       = want && (forced || !i_cpu_en);
   assign rom_addr_d  = (i_cpu_en && !forced) ? i_cpu_addr : want ? addr_q : rom_addr_q;
   assign o_rom_addr  = rom_addr_d;
   assign o_cpu_data  = i_rom_data;
   assign o_cpu_stall = forced;
   assign o_dbg_busy  = state_q != IDLE;
   assign o_dbg_done  = empty_done_q || (state_q == DRAIN && fifo_empty && !inflight_q);
   assign starve_d    = issue ? 32'd0 : want ? starve_q + 32'd1 : starve_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      empty_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            empty_done_d = i_dbg_start && (i_dbg_len == '0);
            if (i_dbg_start && i_dbg_len != '0) begin
               state_d = RUN;
               addr_d  = i_dbg_addr;
               rem_d   = i_dbg_len;
            end
         end
         RUN: begin
            if (issue) begin
               addr_d  = addr_q + 16'd1;
               rem_d   = rem_q - 16'd1;
               state_d = (rem_q == 16'd1) ? DRAIN : RUN;
            end
         end
         DRAIN: state_d = (fifo_empty && !inflight_q) ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         rom_addr_q   <= '0;
         starve_q     <= '0;
         inflight_q   <= 1'b0;
         empty_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         rom_addr_q   <= rom_addr_d;
         starve_q     <= starve_d;
         inflight_q   <= issue;
         empty_done_q <= empty_done_d;
      end
   end
endmodule
